// File: rtl/llr_frame_loader.sv
// llr_frame_loader
// Loads one frame of channel LLRs into the variable-node RAM's initial-store
// port. Each accepted sample is arithmetically shifted, clamped to the RAM's
// LLR width and written one cycle after acceptance. flag_first_store is held
// for the whole load, and load_done marks the final write.
//
// Optional feature macro: LLR_SYM_SAT_EN
//   defined   -> symmetric clamp range [-(2^(DATA_W-1)-1), 2^(DATA_W-1)-1]
//   undefined -> two's complement range  [-2^(DATA_W-1),    2^(DATA_W-1)-1]
module llr_frame_loader #(
  parameter int IN_W      = 8,
  parameter int DATA_W    = 4,
  parameter int ADDR_W    = 8,
  parameter int FRAME_LEN = 128,
  parameter int SHIFT     = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [IN_W-1:0]   in_llr,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] org_addr,
  output logic [DATA_W-1:0] org_data,
  output logic              org_wr_en,
  output logic              flag_first_store,
  output logic              load_done,
  output logic              busy,
  output logic [7:0]        sat_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    LAST = 2'd2
  } state_t;

  // Index of the last sample of a frame; reaching it ends the LOAD phase.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  // Clamp limits, both at input width (for the signed compare) and at RAM
  // width (for the value actually written).
  localparam int HI_INT = (2 ** (DATA_W - 1)) - 1;
`ifdef LLR_SYM_SAT_EN
  localparam int LO_INT = -((2 ** (DATA_W - 1)) - 1);
`else
  localparam int LO_INT = -(2 ** (DATA_W - 1));
`endif
  localparam logic signed [IN_W-1:0] CLAMP_HI   = IN_W'(HI_INT);
  localparam logic signed [IN_W-1:0] CLAMP_LO   = IN_W'(LO_INT);
  localparam logic [DATA_W-1:0]      CLAMP_HI_Q = DATA_W'(HI_INT);
  localparam logic [DATA_W-1:0]      CLAMP_LO_Q = DATA_W'(LO_INT);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [7:0]          sat_cnt_q, sat_cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                done_q, done_d;

  logic signed [IN_W-1:0] shifted;
  logic [DATA_W-1:0]      quant_data;
  logic                   quant_sat;

  // Quantizer: sign-preserving shift, then clamp into the RAM LLR range.
  always_comb begin
    shifted    = $signed(in_llr) >>> SHIFT;
    quant_data = shifted[DATA_W-1:0];
    quant_sat  = 1'b0;
    if (shifted > CLAMP_HI) begin
      quant_data = CLAMP_HI_Q;
      quant_sat  = 1'b1;
    end else if (shifted < CLAMP_LO) begin
      quant_data = CLAMP_LO_Q;
      quant_sat  = 1'b1;
    end
  end

  // Next-state and write-path logic; every register holds unless updated.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sat_cnt_d = sat_cnt_q;
    wr_en_d   = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // abort takes priority over a simultaneous start
        if (start && !abort) begin
          state_d   = LOAD;
          cnt_d     = '0;
          sat_cnt_d = '0;
        end
      end

      LOAD: begin
        if (abort) begin
          // A sample handshaken in the abort cycle is dropped, never written.
          state_d = IDLE;
        end else if (in_valid) begin
          wr_en_d = 1'b1;
          addr_d  = cnt_q;
          data_d  = quant_data;
          cnt_d   = cnt_q + ADDR_ONE;
          if (quant_sat && (sat_cnt_q != 8'hFF)) begin
            sat_cnt_d = sat_cnt_q + 8'd1;
          end
          if (cnt_q == LAST_IDX) begin
            state_d = LAST;
            done_d  = 1'b1;
          end
        end
      end

      LAST: begin
        // The final write is on the outputs during this single cycle.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared immediately by the async reset.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sat_cnt_q <= '0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sat_cnt_q <= sat_cnt_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  // Handshake and status flags are pure functions of the current state.
  assign in_ready         = (state_q == LOAD);
  assign busy             = (state_q != IDLE);
  assign flag_first_store = (state_q != IDLE);

  assign org_wr_en = wr_en_q;
  assign org_addr  = addr_q;
  assign org_data  = data_q;
  assign load_done = done_q;
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_llr_frame_loader.sv
// Self-checking bench for llr_frame_loader: a transaction-level model predicts
// the write stream and status flags; a negedge process compares every cycle.
`timescale 1ns/1ps
module tb_llr_frame_loader;

  localparam int IN_W      = 8;
  localparam int DATA_W    = 4;
  localparam int ADDR_W    = 8;
  localparam int FRAME_LEN = 128;
  localparam int SHIFT     = 2;
  localparam int QHI       = 7;
`ifdef LLR_SYM_SAT_EN
  localparam int QLO       = -7;
  localparam int EXP_SAT_B = 3;
  localparam int EXP_NEG_Q = 9;
`else
  localparam int QLO       = -8;
  localparam int EXP_SAT_B = 2;
  localparam int EXP_NEG_Q = 8;
`endif

  logic                   sys_clk  = 1'b0;
  logic                   sys_rst  = 1'b1;
  logic                   start    = 1'b0;
  logic                   abort    = 1'b0;
  logic                   in_valid = 1'b0;
  logic signed [IN_W-1:0] in_llr   = '0;
  logic                   in_ready;
  logic [ADDR_W-1:0]      org_addr;
  logic [DATA_W-1:0]      org_data;
  logic                   org_wr_en;
  logic                   flag_first_store;
  logic                   load_done;
  logic                   busy;
  logic [7:0]             sat_cnt;

  int total = 0;
  int bad   = 0;

  llr_frame_loader #(
    .IN_W(IN_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .FRAME_LEN(FRAME_LEN), .SHIFT(SHIFT)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .abort(abort),
    .in_llr(in_llr), .in_valid(in_valid), .in_ready(in_ready),
    .org_addr(org_addr), .org_data(org_data), .org_wr_en(org_wr_en),
    .flag_first_store(flag_first_store), .load_done(load_done),
    .busy(busy), .sat_cnt(sat_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // ---------------- reference arithmetic ----------------
  function automatic int q_floor(input int v);
    int d;
    d = 1 << SHIFT;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic int q_val(input int v);
    int t;
    t = q_floor(v);
    if (t > QHI) return QHI;
    if (t < QLO) return QLO;
    return t;
  endfunction

  function automatic bit q_sat(input int v);
    return q_val(v) != q_floor(v);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int addr;
    int data;
    bit last;
  } wr_t;

  wr_t exp_q[$];
  int  m_mode = 0;   // 0 idle, 1 accepting samples, 2 final-write cycle
  int  m_idx  = 0;
  int  m_sat  = 0;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_mode <= 0;
      m_idx  <= 0;
      m_sat  <= 0;
      exp_q.delete();
    end else begin
      case (m_mode)
        0: if (start && !abort) begin
             m_mode <= 1;
             m_idx  <= 0;
             m_sat  <= 0;
           end
        1: if (abort) begin
             m_mode <= 0;
           end else if (in_valid) begin
             exp_q.push_back('{addr: m_idx, data: q_val(int'(in_llr)),
                               last: (m_idx == FRAME_LEN - 1)});
             if (q_sat(int'(in_llr)) && m_sat < 255) m_sat <= m_sat + 1;
             if (m_idx == FRAME_LEN - 1) m_mode <= 2;
             else m_idx <= m_idx + 1;
           end
        default: m_mode <= 0;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  int last_addr = 0;
  int last_data = 0;
  int wr_cnt    = 0;
  int done_cnt  = 0;
  int cap[FRAME_LEN];

  always @(negedge sys_clk) begin
    wr_t w;
    if (sys_rst) begin
      last_addr = 0;
      last_data = 0;
    end
    check("in_ready", int'(in_ready), int'(m_mode == 1));
    check("busy", int'(busy), int'(m_mode != 0));
    check("flag_first_store", int'(flag_first_store), int'(m_mode != 0));
    check("sat_cnt", int'(sat_cnt), m_sat);
    if (org_wr_en) wr_cnt++;
    if (load_done) done_cnt++;
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      last_addr = w.addr;
      last_data = w.data & 15;
      check("org_wr_en", int'(org_wr_en), 1);
      check("load_done", int'(load_done), int'(w.last));
      if (w.addr >= 0 && w.addr < FRAME_LEN) cap[w.addr] = int'(org_data);
    end else begin
      check("org_wr_en", int'(org_wr_en), 0);
      check("load_done", int'(load_done), 0);
    end
    check("org_addr", int'(org_addr), last_addr);
    check("org_data", int'(org_data), last_data);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic int dir_val(input int i);
    case (i)
      0: return 127;
      1: return -128;
      2: return 28;
      3: return -29;
      default: return 0;
    endcase
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_mode != 0 && n < 8) begin
      cyc();
      n++;
    end
    if (m_mode != 0) check("idle_timeout", m_mode, 0);
  endtask

  // pat: 0 = i%32, 1 = directed saturation set, 2 = random
  // vmode: 0 = continuous, 1 = toggling, 2 = random valid
  task automatic run_frame(input int pat, input int vmode, input int abort_at,
                           input bit start_mid);
    int acc;
    int guard;
    bit will;
    bit ab;
    acc = 0;
    guard = 0;
    wr_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < FRAME_LEN; i++) cap[i] = -1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    while (acc < FRAME_LEN && guard < 4000) begin
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (guard % 2 == 0);
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      case (pat)
        0:       in_llr = IN_W'(acc % 32);
        1:       in_llr = IN_W'(dir_val(acc));
        default: in_llr = IN_W'($urandom_range(0, 255));
      endcase
      ab = (abort_at >= 0) && (acc == abort_at) && in_valid;
      abort = ab;
      start = start_mid && (guard == 40);
      will = in_valid && (m_mode == 1);
      cyc();
      abort = 1'b0;
      start = 1'b0;
      guard++;
      if (ab) break;
      if (will) acc++;
    end
    in_valid = 1'b0;
    if (guard >= 4000) check("frame_timeout", guard, 0);
    wait_idle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_org_addr"}, int'(org_addr), 0);
    check({tag, "_org_data"}, int'(org_data), 0);
    check({tag, "_org_wr_en"}, int'(org_wr_en), 0);
    check({tag, "_flag"}, int'(flag_first_store), 0);
    check({tag, "_load_done"}, int'(load_done), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_sat_cnt"}, int'(sat_cnt), 0);
  endtask

  initial begin
    // Pin the model against hand-computed values.
    check("pin_q127", q_val(127), 7);
    check("pin_q28", q_val(28), 7);
    check("pin_qm1", q_val(-1), -1);
    check("pin_qm29", q_val(-29), QLO);
    check("pin_sat28", int'(q_sat(28)), 0);
    check("pin_sat127", int'(q_sat(127)), 1);

    repeat (3) cyc();
    check_all_zero("reset");
    sys_rst = 1'b0;
    cyc();

    // Continuous frame, no saturation.
    run_frame(0, 0, -1, 1'b0);
    $display("frame A: writes=%0d done=%0d sat=%0d", wr_cnt, done_cnt, sat_cnt);
    check("A_writes", wr_cnt, FRAME_LEN);
    check("A_done", done_cnt, 1);
    check("A_sat", int'(sat_cnt), 0);
    check("A_cap9", cap[9], 2);
    check("A_cap127", cap[127], 7);

    // Directed saturation samples.
    run_frame(1, 0, -1, 1'b0);
    $display("frame B: writes=%0d done=%0d sat=%0d", wr_cnt, done_cnt, sat_cnt);
    check("B_sat", int'(sat_cnt), EXP_SAT_B);
    check("B_cap0", cap[0], 7);
    check("B_cap1", cap[1], EXP_NEG_Q);
    check("B_cap2", cap[2], 7);
    check("B_cap3", cap[3], EXP_NEG_Q);

    // Toggling valid, with a start pulse in mid-load that must be ignored.
    run_frame(2, 1, -1, 1'b1);
    $display("frame C: writes=%0d done=%0d", wr_cnt, done_cnt);
    check("C_writes", wr_cnt, FRAME_LEN);
    check("C_done", done_cnt, 1);

    // Abort on sample 50.
    run_frame(2, 0, 50, 1'b0);
    $display("frame D abort: writes=%0d done=%0d busy=%0d", wr_cnt, done_cnt, busy);
    check("D_writes", wr_cnt, 50);
    check("D_done", done_cnt, 0);
    check("D_busy", int'(busy), 0);
    check("D_cap50", cap[50], -1);

    // Reload after abort starts from address 0.
    run_frame(2, 2, -1, 1'b0);
    $display("frame E reload: writes=%0d done=%0d", wr_cnt, done_cnt);
    check("E_writes", wr_cnt, FRAME_LEN);
    check("E_done", done_cnt, 1);

    // start and abort together while idle.
    start = 1'b1;
    abort = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    cyc();
    $display("start+abort idle: busy=%0d", busy);
    check("SA_busy", int'(busy), 0);

    // Asynchronous reset in mid-frame.
    start = 1'b1;
    cyc();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      in_llr = IN_W'($urandom_range(0, 255));
      cyc();
    end
    @(posedge sys_clk);
    #3;
    sys_rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    $display("async reset mid-frame: busy=%0d wr_en=%0d", busy, org_wr_en);
    in_valid = 1'b0;
    repeat (2) cyc();
    sys_rst = 1'b0;
    cyc();
    check("post_rst_busy", int'(busy), 0);

    // A few random frames.
    for (int f = 0; f < 3; f++) begin
      run_frame(2, 2, -1, 1'b0);
      $display("random frame %0d: writes=%0d done=%0d sat=%0d", f, wr_cnt, done_cnt, sat_cnt);
      check("R_writes", wr_cnt, FRAME_LEN);
      check("R_done", done_cnt, 1);
    end

    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
